// File: rtl/disp_pkg.sv
// disp_pkg: shared types and helpers for the display scan controller.
//   scan_state_t : slot phase (BLANK = outputs dark, DRIVE = digit lit)
//   SEG_OFF      : segment bus value with every segment and dp dark
//   idx_w()      : bit width needed to index `digits` slots (minimum 1)
package disp_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [7:0] SEG_OFF = 8'h00;

  function automatic int unsigned idx_w(input int unsigned digits);
    return (digits > 1) ? int'($clog2(digits)) : 1;
  endfunction

endpackage

// File: rtl/displaydigit.sv
// displaydigit: hex nibble to 7-segment decoder, active-high segments.
//   hex : 4-bit value 0..F
//   seg : segments a..g in bits 6..0
module displaydigit (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      4'hF: seg = 7'h47;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed 7-segment scan controller.
//   clk, rst   : clock, asynchronous active-high reset
//   value      : DIGITS hex nibbles, digit 0 in bits 3:0
//   dp_in      : decimal point per digit
//   load       : strobe capturing value/dp_in (applied at next frame wrap)
//   seg        : segments a..g in bits 7..1, dp in bit 0, active-high
//   an         : one-hot digit enable, all-zero while blanking
//   digit_idx  : current slot index
//   frame_done : high during the last cycle of slot DIGITS-1
// Build option: define DISPLAY_SCAN_LZB_EN for leading-zero blanking.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*DIGITS-1:0]       value,
  input  logic [DIGITS-1:0]         dp_in,
  input  logic                      load,
  output logic [7:0]                seg,
  output logic [DIGITS-1:0]         an,
  output logic [idx_w(DIGITS)-1:0]  digit_idx,
  output logic                      frame_done
);

  localparam int unsigned IW = idx_w(DIGITS);
  localparam int unsigned CW = idx_w(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_DRV  = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  scan_state_t          state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx_n;
  logic                 fd_n;
  logic [7:0]           seg_n;
  logic [DIGITS-1:0]    an_n;

  logic [4*DIGITS-1:0]  act_val, pend_val;
  logic [DIGITS-1:0]    act_dp, pend_dp;
  logic                 pend_valid;

  logic [3:0]           nib;
  logic                 dp_sel;
  logic                 blank_sel;
  logic [DIGITS-1:0]    lz;
  logic [6:0]           dec_seg;

  // Next slot position and phase.
  always_comb begin
    cnt_n   = cnt + 1'b1;
    idx_n   = digit_idx;
    state_n = state;
    if (cnt == CNT_LAST) begin
      cnt_n = '0;
      idx_n = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    end
    case (state)
      BLANK:   if (cnt_n == CNT_DRV) state_n = DRIVE;
      DRIVE:   if (cnt == CNT_LAST)  state_n = BLANK;
      default: state_n = BLANK;
    endcase
    fd_n = (cnt_n == CNT_LAST) && (idx_n == IDX_LAST);
  end

`ifdef DISPLAY_SCAN_LZB_EN
  // lz[i]: digits i..DIGITS-1 are all zero; digit 0 is never blanked.
  always_comb begin
    logic all_zero;
    lz       = '0;
    all_zero = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (act_val[4*i +: 4] == 4'h0);
      lz[i]    = all_zero;
    end
  end
`else
  assign lz = '0;
`endif

  // Select the active nibble for the upcoming slot. The active buffer only
  // changes on the wrap, which always enters BLANK, so it is stable whenever
  // its decode reaches the outputs.
  always_comb begin
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_n == IW'(i)) begin
        nib       = act_val[4*i +: 4];
        dp_sel    = act_dp[i];
        blank_sel = lz[i];
      end
    end
  end

  displaydigit u_dec (
    .hex (nib),
    .seg (dec_seg)
  );

  always_comb begin
    seg_n = SEG_OFF;
    an_n  = '0;
    if (state_n == DRIVE) begin
      for (int unsigned i = 0; i < DIGITS; i++) an_n[i] = (idx_n == IW'(i));
      seg_n = {(blank_sel ? 7'h00 : dec_seg), dp_sel};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      digit_idx  <= '0;
      frame_done <= 1'b0;
      seg        <= SEG_OFF;
      an         <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      digit_idx  <= idx_n;
      frame_done <= fd_n;
      seg        <= seg_n;
      an         <= an_n;
    end
  end

  // Double buffer: a load on the wrap cycle bypasses pending straight to
  // active; otherwise pending is promoted on the wrap if it holds data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_val    <= '0;
      act_dp     <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
      end
      if (frame_done) begin
        pend_valid <= 1'b0;
        if (load) begin
          act_val <= value;
          act_dp  <= dp_in;
        end else if (pend_valid) begin
          act_val <= pend_val;
          act_dp  <= pend_dp;
        end
      end else if (load) begin
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed bench for display_scan_ctrl with
// DIGITS=4, TICK_DIV=8, BLANK_CYC=2. Expected segment patterns are packed
// per frame with digit d in bits 8d+7:8d.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  logic [31:0] fa, fb, pat;
  logic [3:0]  ea;
  logic [7:0]  es;
  int          p, d;

`ifdef DISPLAY_SCAN_LZB_EN
  localparam logic [7:0] ZB = 8'h00;
`else
  localparam logic [7:0] ZB = 8'hFC;
`endif

  display_scan_ctrl #(.DIGITS(4), .TICK_DIV(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    cmp_cnt++;
    if (seg !== 8'h00 || an !== 4'b0000 || digit_idx !== 2'd0 || frame_done !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_values seg=%h an=%b idx=%0d fd=%b required 00 0000 0 0",
               seg, an, digit_idx, frame_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_scan();
    pat = {ZB, ZB, ZB, 8'hFC};
    for (int c = 0; c < 32; c++) begin
      p  = c % 8;
      d  = c / 8;
      ea = (p < 2) ? 4'b0000 : 4'(1 << d);
      es = (p < 2) ? 8'h00 : pat[8*d +: 8];
      cmp_cnt++;
      if (an !== ea || seg !== es || digit_idx !== 2'(d) || frame_done !== (c == 31)) begin
        fail_cnt++;
        $display("FAIL idle_scan c=%0d an=%b/%b seg=%h/%h idx=%0d/%0d fd=%b/%b",
                 c, an, ea, seg, es, digit_idx, d, frame_done, (c == 31));
      end
      step();
    end
  endtask

  task automatic test_load_mid_frame();
    fa = {ZB, ZB, ZB, 8'hFC};
    fb = {8'hDA, 8'h61, 8'hEE, 8'hFC};
    for (int c = 0; c < 64; c++) begin
      load = (c == 10);
      if (c == 10) begin
        value = 16'h21A0;
        dp_in = 4'b0100;
      end
      pat = (c < 32) ? fa : fb;
      p   = c % 8;
      d   = (c % 32) / 8;
      ea  = (p < 2) ? 4'b0000 : 4'(1 << d);
      es  = (p < 2) ? 8'h00 : pat[8*d +: 8];
      cmp_cnt++;
      if (an !== ea || seg !== es) begin
        fail_cnt++;
        $display("FAIL load_mid_frame c=%0d an=%b/%b seg=%h/%h", c, an, ea, seg, es);
      end
      step();
    end
    load = 1'b0;
  endtask

  task automatic test_double_load();
    fa = {8'hDA, 8'h61, 8'hEE, 8'hFC};
    fb = {4{8'hDA}};
    for (int c = 0; c < 64; c++) begin
      load = (c == 3) || (c == 20);
      dp_in = 4'b0000;
      if (c == 3)  value = 16'h1111;
      if (c == 20) value = 16'h2222;
      pat = (c < 32) ? fa : fb;
      p   = c % 8;
      d   = (c % 32) / 8;
      ea  = (p < 2) ? 4'b0000 : 4'(1 << d);
      es  = (p < 2) ? 8'h00 : pat[8*d +: 8];
      cmp_cnt++;
      if (an !== ea || seg !== es) begin
        fail_cnt++;
        $display("FAIL double_load c=%0d an=%b/%b seg=%h/%h", c, an, ea, seg, es);
      end
      step();
    end
    load = 1'b0;
  endtask

  task automatic test_load_on_wrap();
    fa = {4{8'hDA}};
    fb = {ZB, ZB, ZB, 8'h60};
    for (int c = 0; c < 64; c++) begin
      load = (c == 31);
      if (c == 31) begin
        value = 16'h0001;
        dp_in = 4'b0000;
        cmp_cnt++;
        if (frame_done !== 1'b1) begin
          fail_cnt++;
          $display("FAIL wrap_frame_done fd=%b required 1", frame_done);
        end
      end
      pat = (c < 32) ? fa : fb;
      p   = c % 8;
      d   = (c % 32) / 8;
      ea  = (p < 2) ? 4'b0000 : 4'(1 << d);
      es  = (p < 2) ? 8'h00 : pat[8*d +: 8];
      cmp_cnt++;
      if (an !== ea || seg !== es) begin
        fail_cnt++;
        $display("FAIL load_on_wrap c=%0d an=%b/%b seg=%h/%h", c, an, ea, seg, es);
      end
      step();
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid_drive();
    pat = {ZB, ZB, ZB, 8'h60};
    for (int c = 0; c <= 20; c++) begin
      load = (c == 5);
      if (c == 5) value = 16'h3333;
      p  = c % 8;
      d  = c / 8;
      ea = (p < 2) ? 4'b0000 : 4'(1 << d);
      es = (p < 2) ? 8'h00 : pat[8*d +: 8];
      cmp_cnt++;
      if (an !== ea || seg !== es) begin
        fail_cnt++;
        $display("FAIL pre_reset c=%0d an=%b/%b seg=%h/%h", c, an, ea, seg, es);
      end
      if (c < 20) step();
    end
    load = 1'b0;
    #2 rst = 1'b1;
    #1;
    cmp_cnt++;
    if (seg !== 8'h00 || an !== 4'b0000 || digit_idx !== 2'd0 || frame_done !== 1'b0) begin
      fail_cnt++;
      $display("FAIL async_reset seg=%h an=%b idx=%0d fd=%b required 00 0000 0 0",
               seg, an, digit_idx, frame_done);
    end
    step();
    rst = 1'b0;
    pat = {ZB, ZB, ZB, 8'hFC};
    for (int c = 0; c < 64; c++) begin
      p  = c % 8;
      d  = (c % 32) / 8;
      ea = (p < 2) ? 4'b0000 : 4'(1 << d);
      es = (p < 2) ? 8'h00 : pat[8*d +: 8];
      cmp_cnt++;
      if (an !== ea || seg !== es || digit_idx !== 2'(d)) begin
        fail_cnt++;
        $display("FAIL post_reset c=%0d an=%b/%b seg=%h/%h idx=%0d/%0d",
                 c, an, ea, seg, es, digit_idx, d);
      end
      step();
    end
  endtask

  task automatic test_leading_zero();
    fa = {ZB, ZB, ZB, 8'hFC};
    fb = {ZB, ZB, 8'hDA, 8'hFC};
    for (int c = 0; c < 64; c++) begin
      load = (c == 0);
      if (c == 0) begin
        value = 16'h0020;
        dp_in = 4'b0000;
      end
      pat = (c < 32) ? fa : fb;
      p   = c % 8;
      d   = (c % 32) / 8;
      ea  = (p < 2) ? 4'b0000 : 4'(1 << d);
      es  = (p < 2) ? 8'h00 : pat[8*d +: 8];
      cmp_cnt++;
      if (an !== ea || seg !== es) begin
        fail_cnt++;
        $display("FAIL leading_zero c=%0d an=%b/%b seg=%h/%h", c, an, ea, seg, es);
      end
      step();
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_load_mid_frame();
    test_double_load();
    test_load_on_wrap();
    test_reset_mid_drive();
    test_leading_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
